// File: rtl/seg7_pkg.sv
// Shared seven-segment coding: digit codes, dash/blank, converter state enum.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package seg7_pkg;

    localparam int SEG_W = 7;

    // abcdefg, bit6 = a, active-high
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE, DONE} state_t;

    // BCD nibble to segment code; non-decimal nibbles show a dash
    function automatic logic [SEG_W-1:0] digit_code(input logic [3:0] d);
        logic [SEG_W-1:0] code;
        case (d)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// One BCD digit to seven-segment code, with forced-blank input.
// Latency: combinational.
// Backpressure: none.
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0]       bcd,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    assign seg = blank ? SEG_BLANK : digit_code(bcd);

endmodule

// File: rtl/seg7_product_encoder.sv
// Signed product to sign flag + DIGITS seven-segment codes via double-dabble; SEG7_BLANK_LEADING_EN blanks leading zeros.
// Latency: out_valid rises IN_W+2 clocks after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module seg7_product_encoder
    import seg7_pkg::*;
#(
    parameter int IN_W   = 15,
    parameter int DIGITS = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_product,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_neg,
    output logic                    out_ovf,
    output logic [SEG_W*DIGITS-1:0] out_seg
);

    // one guard digit above the displayed ones catches |value| >= 10^DIGITS
    localparam int BCD_W = (DIGITS + 1) * 4;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t                    state;
    state_t                    state_nxt;
    logic                      neg;
    logic [IN_W-1:0]           mag;
    logic [BCD_W-1:0]          bcd;
    logic [BCD_W-1:0]          bcd_adj;
    logic [CNT_W-1:0]          count;
    logic                      accept;
    logic                      shift_done;
    logic                      ovf_now;
    logic [DIGITS-1:0]         blank;
    logic [SEG_W*DIGITS-1:0]   seg_dig;

    assign in_ready   = (state == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == DONE);
    // count holds completed shifts; the cycle that sees IN_W hands over to ENCODE
    assign shift_done = (count == CNT_W'(IN_W));
    assign ovf_now    = (bcd[BCD_W-1 -: 4] != 4'd0);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)               state_nxt = SHIFT;
            SHIFT:   if (shift_done)           state_nxt = ENCODE;
            ENCODE:                            state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // add-3 correction on every nibble that would overflow decimal after the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i <= DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

`ifdef SEG7_BLANK_LEADING_EN
    logic lead;
`endif

    // leading-zero blanking above the units digit (units always shows)
    always_comb begin
        blank = '0;
`ifdef SEG7_BLANK_LEADING_EN
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (bcd[i*4 +: 4] != 4'd0) lead = 1'b0;
            blank[i] = lead;
        end
`endif
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg7_digit_enc u_enc (
            .bcd   (bcd[g*4 +: 4]),
            .blank (blank[g]),
            .seg   (seg_dig[g*SEG_W +: SEG_W])
        );
    end

    // conversion datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            neg     <= 1'b0;
            mag     <= '0;
            bcd     <= '0;
            count   <= '0;
            out_neg <= 1'b0;
            out_ovf <= 1'b0;
            out_seg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        neg   <= in_product[IN_W-1];
                        // -2^(IN_W-1) negates to itself, which reads correctly as unsigned
                        mag   <= in_product[IN_W-1] ? (~in_product + 1'b1) : in_product;
                        bcd   <= '0;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    if (!shift_done) begin
                        {bcd, mag} <= {bcd_adj, mag} << 1;
                        count      <= count + 1'b1;
                    end
                end
                ENCODE: begin
                    out_neg <= neg;
                    out_ovf <= ovf_now;
                    out_seg <= ovf_now ? {DIGITS{SEG_DASH}} : seg_dig;
                end
                default: ;
            endcase
        end
    end

endmodule
